// File: rtl/sig_dac_tx_if.sv
// Sample input and serial DAC pins of the output stage.
// The transmitter sits on the slave side and drives the DAC pins.
interface sig_dac_tx_if;
    logic [15:0] sig;
    logic        en;
    logic        dac_sync;
    logic        dac_sclk;
    logic        dac_din;
    logic        busy;
    logic        frame_done;

    modport master (
        output sig, en,
        input  dac_sync, dac_sclk, dac_din, busy, frame_done
    );

    modport slave (
        input  sig, en,
        output dac_sync, dac_sclk, dac_din, busy, frame_done
    );
endinterface

// File: rtl/sig_dac_tx.sv
// Serial DAC transmitter: on each sample tick, captures sig[15:4] and shifts it
// out as a 16-bit SYNC/SCLK/DIN frame with SCLK = clk/2.
module sig_dac_tx #(
    parameter int unsigned SAMPLE_DIV = 40
) (
    input  logic         clk,
    input  logic         rst_n,
    sig_dac_tx_if.slave  bus
);
    localparam int unsigned DIV_W   = 16;
    localparam int unsigned FRAME_W = 16;
    localparam int unsigned BIT_W   = 4;
    localparam int unsigned CODE_W  = 12;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             r_state, w_state_d;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [FRAME_W-1:0] r_shreg, w_shreg_d;
    logic [BIT_W-1:0]   r_bit_cnt, w_bit_cnt_d;
    logic               r_phase, w_phase_d;
    logic               r_sync, w_sync_d;
    logic               r_sclk, w_sclk_d;
    logic               r_din, w_din_d;
    logic               r_busy, w_busy_d;
    logic               r_done, w_done_d;
    logic               w_tick;
    logic [FRAME_W-1:0] w_load_word;
    logic               w_unused_lsb;

    // The DAC code is a plain truncation; the low nibble is dropped on purpose.
    assign w_load_word  = {4'b0000, bus.sig[15:FRAME_W-CODE_W]};
    assign w_unused_lsb = ^bus.sig[FRAME_W-CODE_W-1:0];
    assign w_tick       = (r_div_cnt == DIV_LAST);

    // Free-running sample-rate divider, independent of enable and state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_phase   <= 1'b0;
            r_sync    <= 1'b1;
            r_sclk    <= 1'b1;
            r_din     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_shreg   <= w_shreg_d;
            r_bit_cnt <= w_bit_cnt_d;
            r_phase   <= w_phase_d;
            r_sync    <= w_sync_d;
            r_sclk    <= w_sclk_d;
            r_din     <= w_din_d;
            r_busy    <= w_busy_d;
            r_done    <= w_done_d;
        end
    end

    // Outputs are computed as next values so pins change exactly on the edge.
    always_comb begin
        w_state_d   = r_state;
        w_shreg_d   = r_shreg;
        w_bit_cnt_d = r_bit_cnt;
        w_phase_d   = r_phase;
        w_sync_d    = r_sync;
        w_sclk_d    = r_sclk;
        w_din_d     = r_din;
        w_busy_d    = r_busy;
        w_done_d    = 1'b0;

        case (r_state)
            IDLE: begin
                w_sync_d = 1'b1;
                w_sclk_d = 1'b1;
                w_din_d  = 1'b0;
                w_busy_d = 1'b0;
                if (w_tick && bus.en) begin
                    w_state_d   = SHIFT;
                    w_shreg_d   = w_load_word;
                    w_bit_cnt_d = '0;
                    w_phase_d   = 1'b0;
                    w_sync_d    = 1'b0;
                    w_busy_d    = 1'b1;
                    w_din_d     = w_load_word[FRAME_W-1];
                end
            end
            SHIFT: begin
                w_phase_d = ~r_phase;
                if (!r_phase) begin
                    w_sclk_d = 1'b0;
                end else if (r_bit_cnt == BIT_LAST) begin
                    w_state_d = IDLE;
                    w_sync_d  = 1'b1;
                    w_sclk_d  = 1'b1;
                    w_din_d   = 1'b0;
                    w_busy_d  = 1'b0;
                    w_done_d  = 1'b1;
                end else begin
                    w_shreg_d   = {r_shreg[FRAME_W-2:0], 1'b0};
                    w_bit_cnt_d = r_bit_cnt + BIT_W'(1);
                    w_sclk_d    = 1'b1;
                    w_din_d     = r_shreg[FRAME_W-2];
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    assign bus.dac_sync   = r_sync;
    assign bus.dac_sclk   = r_sclk;
    assign bus.dac_din    = r_din;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_done;
endmodule

// File: tb/tb_sig_dac_tx.sv
// Directed bench for sig_dac_tx: frame content, frame timing, enable and reset.
module tb_sig_dac_tx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   edge_n = 0;
    int   base = 0;

    sig_dac_tx_if bus ();

    sig_dac_tx #(.SAMPLE_DIV(40)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Index of the last rising edge, counted from the first edge after reset release.
    function automatic int rel();
        return edge_n - base - 1;
    endfunction

    task automatic wait_fall(output int idx);
        bit ok = 1'b0;
        idx = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.dac_sync == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check("sync_fall_seen", 32'(ok), 32'd1);
        if (ok) idx = rel();
    endtask

    // Captures one frame as the DAC would: DIN latched on each falling SCLK.
    task automatic run_frame(input int chg_at, input logic [15:0] chg_val, input int en_off_at,
                             output logic [15:0] word, output int falls,
                             output int fall_idx, output int rise_idx);
        int   low_n = 0;
        int   k;
        logic prev_sclk = 1'b1;
        word = '0;
        falls = 0;
        rise_idx = -1;
        wait_fall(fall_idx);
        if (fall_idx < 0) return;
        check("busy_in_frame", 32'(bus.busy), 32'd1);
        while (bus.dac_sync == 1'b0 && low_n < 100) begin
            low_n++;
            k = rel() - fall_idx;
            if (k == chg_at) bus.sig = chg_val;
            if (k == en_off_at) bus.en = 1'b0;
            if (prev_sclk && !bus.dac_sclk) begin
                word = {word[14:0], bus.dac_din};
                falls++;
            end
            prev_sclk = bus.dac_sclk;
            @(negedge clk);
        end
        rise_idx = rel();
        check("sync_low_cycles", 32'(low_n), 32'd32);
        check("done_pulse", 32'(bus.frame_done), 32'd1);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_sclk", 32'(bus.dac_sclk), 32'd1);
        check("idle_din", 32'(bus.dac_din), 32'd0);
        @(negedge clk);
        check("done_clear", 32'(bus.frame_done), 32'd0);
    endtask

    logic [15:0] tbl [10] = '{16'h0010, 16'h7FF0, 16'h8008, 16'hC3A5, 16'h5A5A,
                              16'h0001, 16'hFFF0, 16'h1111, 16'hEDCB, 16'h2468};

    initial begin
        logic [15:0] word;
        int falls, f_idx, r_idx, prev_f, prev_r, e, exp_f, low_cnt;

        bus.sig = 16'hABCD;
        bus.en  = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_sync", 32'(bus.dac_sync), 32'd1);
        check("rst_sclk", 32'(bus.dac_sclk), 32'd1);
        check("rst_din", 32'(bus.dac_din), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.frame_done), 32'd0);

        rst_n  = 1'b1;
        bus.en = 1'b1;
        base   = edge_n;
        run_frame(-1, 16'h0, -1, word, falls, f_idx, r_idx);
        check("first_fall_edge", 32'(f_idx), 32'd39);
        check("word_abcd", 32'(word), 32'h0ABC);
        check("falls_abcd", 32'(falls), 32'd16);
        check("done_after_32", 32'(r_idx - f_idx), 32'd32);
        prev_f = f_idx; prev_r = r_idx;

        bus.sig = 16'hFFFF;
        run_frame(-1, 16'h0, -1, word, falls, f_idx, r_idx);
        check("word_ffff", 32'(word), 32'h0FFF);
        check("period_ffff", 32'(f_idx - prev_f), 32'd40);
        prev_f = f_idx; prev_r = r_idx;

        bus.sig = 16'h000F;
        run_frame(-1, 16'h0, -1, word, falls, f_idx, r_idx);
        check("word_000f", 32'(word), 32'h0000);
        prev_f = f_idx; prev_r = r_idx;

        for (int i = 0; i < 10; i++) begin
            bus.sig = tbl[i];
            run_frame(-1, 16'h0, -1, word, falls, f_idx, r_idx);
            check($sformatf("word_tbl%0d", i), 32'(word), 32'({4'b0000, tbl[i][15:4]}));
            check($sformatf("period_%0d", i), 32'(f_idx - prev_f), 32'd40);
            check($sformatf("sync_high_%0d", i), 32'(f_idx - prev_r), 32'd8);
            prev_f = f_idx; prev_r = r_idx;
        end

        bus.sig = 16'h1234;
        run_frame(10, 16'h8000, -1, word, falls, f_idx, r_idx);
        check("word_midchange", 32'(word), 32'h0123);
        run_frame(-1, 16'h0, -1, word, falls, f_idx, r_idx);
        check("word_after_change", 32'(word), 32'h0800);

        run_frame(-1, 16'h0, 5, word, falls, f_idx, r_idx);
        check("en_drop_falls", 32'(falls), 32'd16);
        check("en_drop_word", 32'(word), 32'h0800);
        low_cnt = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.dac_sync == 1'b0 || bus.busy == 1'b1) low_cnt++;
        end
        check("no_frame_while_off", 32'(low_cnt), 32'd0);
        bus.en = 1'b1;
        e = rel();
        exp_f = e + 1 + ((39 - ((e + 1) % 40) + 40) % 40);
        run_frame(-1, 16'h0, -1, word, falls, f_idx, r_idx);
        check("reenable_fall", 32'(f_idx), 32'(exp_f));
        check("reenable_phase", 32'(f_idx % 40), 32'd39);

        bus.sig = 16'h9876;
        wait_fall(f_idx);
        repeat (17) @(posedge clk);
        #1;
        check("pre_rst_sync_low", 32'(bus.dac_sync), 32'd0);
        rst_n = 1'b0;
        #1;
        check("arst_sync", 32'(bus.dac_sync), 32'd1);
        check("arst_sclk", 32'(bus.dac_sclk), 32'd1);
        check("arst_din", 32'(bus.dac_din), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.frame_done), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base  = edge_n;
        run_frame(-1, 16'h0, -1, word, falls, f_idx, r_idx);
        check("post_rst_fall_edge", 32'(f_idx), 32'd39);
        check("post_rst_word", 32'(word), 32'h0987);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sig_dac_tx.md
# sig_dac_tx

Serial DAC transmitter at the output end of the synthesiser signal chain. On every sample tick it captures the 16-bit mixed signal `sig`, truncates it to a 12-bit DAC code and shifts it out as one 16-bit SPI-style frame (SYNC/SCLK/DIN) to the on-board 12-bit DAC. It runs on the 1 MHz system clock and generates its own sample rate and SCLK (clk/2).

## Interface

Parameters:
- `SAMPLE_DIV`, default 40: clk cycles per sample (40 gives 25 kHz at 1 MHz). Valid range is 34..65535; smaller values are unsupported.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input, 1 bit: 1 MHz system clock; all logic is on the rising edge.
- `rst_n` input, 1 bit: asynchronous active-low reset.
- `sig` input, 16 bits: unsigned mixed audio sample.
- `en` input, 1 bit: when high, a frame starts on each tick.
- `dac_sync` output, 1 bit: frame select, active low.
- `dac_sclk` output, 1 bit: serial clock; the DAC samples `dac_din` on its falling edge.
- `dac_din` output, 1 bit: serial data, MSB first.
- `busy` output, 1 bit: high while a frame is in flight.
- `frame_done` output, 1 bit: one-cycle pulse when a frame completes.

## Operation

- The divider `div_cnt` (16 bits) resets to 0, increments every cycle and wraps from `SAMPLE_DIV-1` to 0. It runs regardless of `en` or state.
- `tick` = (`div_cnt == SAMPLE_DIV-1`).
- The FSM has two states: IDLE and SHIFT.
- **IDLE → SHIFT** on `tick && en`:
  - Load the shift register with {4'b0000, sig[15:4]}. The 4 control bits are 00 (normal mode) and the rest are 12 data bits.
  - Clear `bit_cnt` (4 bits) and `phase` (1 bit).
- **In SHIFT**, `phase` toggles every cycle.
  - phase 0: `dac_sclk`=1 and `dac_din` = shreg[15].
  - phase 1: `dac_sclk`=0. At the end of phase 1 the register shifts left and `bit_cnt` increments.
- **SHIFT → IDLE** at the end of phase 1 with `bit_cnt`==15. On that transition, `frame_done` pulses.
- In IDLE: `dac_sync`=1, `dac_sclk`=1, `dac_din`=0, `busy`=0.
- `tick` during SHIFT is ignored. This cannot occur for legal `SAMPLE_DIV`.
- `sig` is sampled only at the load edge. Changes during a frame do not affect that frame.
- If `en` is deasserted mid-frame, the frame completes normally and no further frames start. If `en` is reasserted, the next frame starts on the next tick; there is no partial-period start.
- Width rule: the DAC code is exactly sig[15:4], with no rounding and no saturation. Bits [3:0] are discarded.

## Timing

- Reset (asynchronous, immediate, including mid-frame) forces:
  - `dac_sync`=1, `dac_sclk`=1, `dac_din`=0, `busy`=0, `frame_done`=0.
  - `div_cnt`=0 and state IDLE.
  - An aborted frame is not resumed.
- After release, the first tick is the rising edge on which `div_cnt` reaches `SAMPLE_DIV-1`, at cycle `SAMPLE_DIV-1`.
- All outputs are registered. Let T be the edge where `tick && en` is sampled in IDLE.
  - After T: `dac_sync`=0, `busy`=1, `dac_sclk`=1, `dac_din`=frame bit 15.
  - Frame bit 15-k is driven after edge T+2k, and `dac_sclk` falls after edge T+2k+1 (k = 0..15).
  - After T+32: `dac_sync`=1, `dac_sclk`=1, `dac_din`=0, `busy`=0, `frame_done`=1.
  - After T+33: `frame_done`=0.
- SYNC is low for exactly 32 cycles, giving 16 SCLK periods of 2 µs each.
- The next frame starts at T+`SAMPLE_DIV`, so SYNC is high for at least `SAMPLE_DIV`-32 ≥ 2 cycles.
- Data is stable for a full clk cycle on both sides of each falling SCLK edge.

## Test plan

- **Reset values:** hold `rst_n`=0 for 5 cycles → `dac_sync`=1, `dac_sclk`=1, `dac_din`=0, `busy`=0, `frame_done`=0. Release with `en`=1 → `dac_sync` falls after edge 39.
- **Data word:** `sig`=16'hABCD, `en`=1 → bits captured on the 16 falling SCLK edges are 0000_1010_1011_1100, i.e. 16'h0ABC. `frame_done` pulses once, 32 cycles after SYNC falls.
- **Extremes and rate:** `sig`=16'hFFFF → 16'h0FFF, and `sig`=16'h000F → 16'h0000. Over 10 frames the SYNC falling edges are spaced exactly 40 cycles apart and SYNC is high for 8 cycles between frames.
- **Mid-frame input change:** change `sig` from 16'h1234 to 16'h8000 at T+10 → the current frame carries 16'h0123 and the next frame carries 16'h0800.
- **Enable control:** drop `en` at T+5 → the current frame completes with 16 SCLK falls and no further SYNC activity. Reassert `en` → the next frame starts exactly on the next tick, with the divider phase unchanged.
- **Reset mid-frame:** assert `rst_n`=0 at T+17 → outputs return to idle values immediately, with no clock edge needed. After release, the first frame starts after edge 39, relative to the release edge.
